// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads take absolute priority, then a full-screen
// clear sequence, then a small FIFO of paint writes drained in acceptance order.
module vram_arbiter #(
  parameter int VRAM_L     = 76800,
  parameter int ADDR_W     = $clog2(VRAM_L),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              clear_req,
  input  logic [15:0]       clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_ena,
  output logic [15:0]       mem_wr_data,
  input  logic [15:0]       mem_rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(VRAM_L - 1);

  typedef enum logic [0:0] {S_NORMAL = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [15:0]       fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] clear_addr_r;
  logic [15:0]       clear_color_r;
  logic              rd_valid_r;
  logic              push_s, pop_s, clear_write_s;

  // A pending clear request owns the cycle, so the queue head is not written just before the flush.
  assign wr_ready      = (state_r == S_NORMAL) & (count_r < DEPTH_C) & ~clear_req & ~rst;
  assign push_s        = wr_valid & wr_ready;
  assign pop_s         = (state_r == S_NORMAL) & ~rd_req & ~clear_req & ~rst & (count_r != {CNT_W{1'b0}});
  assign clear_write_s = (state_r == S_CLEAR) & ~rd_req & ~rst;
  assign clear_busy    = (state_r == S_CLEAR);
  assign rd_valid      = rd_valid_r;
  assign rd_data       = mem_rd_data;

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    if (rst) begin
      state_nx_s = S_NORMAL;
    end else if (clear_req) begin
      state_nx_s = S_CLEAR;
    end else begin
      case (state_r)
        S_NORMAL: state_nx_s = S_NORMAL;
        S_CLEAR: begin
          if (clear_write_s && (clear_addr_r == LAST_ADDR_C)) state_nx_s = S_NORMAL;
          else                                                 state_nx_s = S_CLEAR;
        end
        default: state_nx_s = S_NORMAL;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_NORMAL;
    else     state_r <= state_nx_s;
  end

  // VRAM port mux: read > clear write > queued write; idle parks on the read address.
  always_comb begin
    mem_addr    = rd_addr;
    mem_wr_ena  = 1'b0;
    mem_wr_data = 16'h0000;
    if (rd_req) begin
      mem_addr = rd_addr;
    end else if (clear_write_s) begin
      mem_addr    = clear_addr_r;
      mem_wr_ena  = 1'b1;
      mem_wr_data = clear_color_r;
    end else if (pop_s) begin
      mem_addr    = fifo_addr_r[rd_ptr_r];
      mem_wr_ena  = 1'b1;
      mem_wr_data = fifo_data_r[rd_ptr_r];
    end else begin
      mem_addr = rd_addr;
    end
  end

  // Queue storage; pushes are already gated by reset through wr_ready.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= wr_addr;
      fifo_data_r[wr_ptr_r] <= wr_data;
    end
  end

  // Queue pointers, clear sequencer and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r    <= 1'b0;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      clear_addr_r  <= {ADDR_W{1'b0}};
      clear_color_r <= 16'h0000;
    end else begin
      rd_valid_r <= rd_req;
      if (clear_req) begin
        clear_color_r <= clear_color;
        clear_addr_r  <= {ADDR_W{1'b0}};
        wr_ptr_r      <= {PTR_W{1'b0}};
        rd_ptr_r      <= {PTR_W{1'b0}};
        count_r       <= {CNT_W{1'b0}};
      end else begin
        // The last address is held rather than wrapped; the FSM leaves S_CLEAR on this edge.
        if (clear_write_s && (clear_addr_r != LAST_ADDR_C))
          clear_addr_r <= clear_addr_r + ADDR_W'(1);
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
